conv_window_reader: RTL and testbench

//  Read-side controller for the inter-layer double data buffer. The producing

---
 rtl/conv_window_reader.sv | 188 ++++++++++++++++++
 tb/tb_conv_window_reader.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_reader.sv
// Read-side sweeper for the inter-layer double buffer: walks every KSIZE x KSIZE
// window of a stored feature map in raster order and hands each one to the conv core.
module conv_window_reader #(
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28,
    parameter int KSIZE      = 5,
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int BASE_ADDR  = 0,
    parameter int RD_LAT     = 1,
    localparam int NPORT     = KSIZE * KSIZE
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [1:0]                  data_fill_cnt,
    output logic                        rd_en,
    output logic [NPORT*ADDR_WIDTH-1:0] rd_addr_NP,
    input  logic [NPORT*WIDTH-1:0]      rd_data_NP,
    output logic [NPORT*WIDTH-1:0]      win_data_NP,
    output logic                        win_valid,
    input  logic                        win_ready,
    output logic [15:0]                 win_row,
    output logic [15:0]                 win_col,
    output logic                        win_last,
    output logic                        frame_done,
    output logic [2:0]                  dbg_state
);

    localparam logic [15:0] OW_M1    = 16'(IMG_W - KSIZE);
    localparam logic [15:0] OH_M1    = 16'(IMG_H - KSIZE);
    localparam logic [15:0] WAIT_END = 16'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_WAIT = 3'd2,
        S_CAP  = 3'd3,
        S_OUT  = 3'd4,
        S_REL  = 3'd5
    } state_t;

    state_t state_q, state_d;
    logic [15:0] r_q, r_d;
    logic [15:0] c_q, c_d;
    logic [15:0] wait_q, wait_d;
    logic        rel_q, rel_d;

    logic                        rd_en_d;
    logic [NPORT*ADDR_WIDTH-1:0] addr_d;
    logic [NPORT*WIDTH-1:0]      wdata_d;
    logic                        valid_d;
    logic [15:0]                 row_d;
    logic [15:0]                 col_d;
    logic                        last_d;
    logic                        done_d;

    // Port k = i*KSIZE + j addresses pixel (r+i, c+j) of the stored map.
    function automatic logic [NPORT*ADDR_WIDTH-1:0] win_addrs(input logic [15:0] r,
                                                              input logic [15:0] c);
        logic [NPORT*ADDR_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < KSIZE; i++) begin
            for (int j = 0; j < KSIZE; j++) begin
                v[(i*KSIZE+j)*ADDR_WIDTH +: ADDR_WIDTH] =
                    ADDR_WIDTH'(BASE_ADDR + ({16'd0, r} + i) * IMG_W + ({16'd0, c} + j));
            end
        end
        return v;
    endfunction

    assign dbg_state = state_q;

    // Handshake: win_valid rises only after capture and then holds window, origin,
    // win_last and rd_addr_NP unchanged until a cycle with win_valid && win_ready;
    // that cycle is the transfer and win_valid drops on the following edge.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        wait_d  = wait_q;
        rel_d   = rel_q;
        rd_en_d = rd_en;
        addr_d  = rd_addr_NP;
        wdata_d = win_data_NP;
        valid_d = win_valid;
        row_d   = win_row;
        col_d   = win_col;
        last_d  = win_last;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (data_fill_cnt != 2'd0) begin
                    rd_en_d = 1'b1;
                    r_d     = 16'd0;
                    c_d     = 16'd0;
                    addr_d  = win_addrs(16'd0, 16'd0);
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                wait_d  = 16'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == WAIT_END) begin
                    state_d = S_CAP;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            S_CAP: begin
                wdata_d = rd_data_NP;
                valid_d = 1'b1;
                row_d   = r_q;
                col_d   = c_q;
                last_d  = (r_q == OH_M1) && (c_q == OW_M1);
                state_d = S_OUT;
            end
            S_OUT: begin
                if (win_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (win_last) begin
                        rd_en_d = 1'b0;
                        done_d  = 1'b1;
                        rel_d   = 1'b0;
                        state_d = S_REL;
                    end else begin
                        if (c_q == OW_M1) begin
                            c_d = 16'd0;
                            r_d = r_q + 16'd1;
                        end else begin
                            c_d = c_q + 16'd1;
                        end
                        addr_d  = win_addrs(r_d, c_d);
                        state_d = S_ADDR;
                    end
                end
            end
            S_REL: begin
                // Two idle cycles give the buffer time to retire the released half.
                if (rel_q) begin
                    rel_d   = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    rel_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            r_q         <= '0;
            c_q         <= '0;
            wait_q      <= '0;
            rel_q       <= 1'b0;
            rd_en       <= 1'b0;
            rd_addr_NP  <= '0;
            win_data_NP <= '0;
            win_valid   <= 1'b0;
            win_row     <= '0;
            win_col     <= '0;
            win_last    <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            c_q         <= c_d;
            wait_q      <= wait_d;
            rel_q       <= rel_d;
            rd_en       <= rd_en_d;
            rd_addr_NP  <= addr_d;
            win_data_NP <= wdata_d;
            win_valid   <= valid_d;
            win_row     <= row_d;
            win_col     <= col_d;
            win_last    <= last_d;
            frame_done  <= done_d;
        end
    end

endmodule

// File: tb/tb_conv_window_reader.sv
// Bench for conv_window_reader on an 8x8 map with 5x5 windows; buffer model returns
// mem[addr] one cycle after the address, and a window queue predicts every transfer.
module tb_conv_window_reader;

    localparam int IMG_W      = 8;
    localparam int IMG_H      = 8;
    localparam int KSIZE      = 5;
    localparam int WIDTH      = 16;
    localparam int ADDR_WIDTH = 16;
    localparam int RD_LAT     = 1;
    localparam int NPORT      = KSIZE * KSIZE;
    localparam int OW         = IMG_W - KSIZE + 1;
    localparam int OH         = IMG_H - KSIZE + 1;
    localparam int VW         = NPORT * WIDTH;

    logic                        clk;
    logic                        rst_n;
    logic [1:0]                  data_fill_cnt;
    logic                        rd_en;
    logic [NPORT*ADDR_WIDTH-1:0] rd_addr_NP;
    logic [NPORT*WIDTH-1:0]      rd_data_NP;
    logic [NPORT*WIDTH-1:0]      win_data_NP;
    logic                        win_valid;
    logic                        win_ready;
    logic [15:0]                 win_row;
    logic [15:0]                 win_col;
    logic                        win_last;
    logic                        frame_done;
    logic [2:0]                  dbg_state;

    conv_window_reader #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .KSIZE(KSIZE), .WIDTH(WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH), .BASE_ADDR(0), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .data_fill_cnt(data_fill_cnt),
        .rd_en(rd_en), .rd_addr_NP(rd_addr_NP), .rd_data_NP(rd_data_NP),
        .win_data_NP(win_data_NP), .win_valid(win_valid), .win_ready(win_ready),
        .win_row(win_row), .win_col(win_col), .win_last(win_last),
        .frame_done(frame_done), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- buffer model ----------------
    logic [15:0] mem [0:255];
    always @(posedge clk) begin
        for (int k = 0; k < NPORT; k++) begin
            rd_data_NP[k*WIDTH +: WIDTH] <= mem[rd_addr_NP[k*ADDR_WIDTH +: 8]];
        end
    end

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    logic [15:0] hs_row_q[$];
    logic [15:0] hs_col_q[$];
    logic [15:0] hs_p0_q[$];
    logic [15:0] hs_p24_q[$];
    int          hs_cyc_q[$];
    int          gap_q[$];
    int          last_cnt = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic        prev_rd_en = 1'b0;
    logic        seen_fall = 1'b0;
    int          low_run = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_wide(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] exp_win(input int r, input int c);
        logic [VW-1:0] v;
        for (int i = 0; i < KSIZE; i++)
            for (int j = 0; j < KSIZE; j++)
                v[(i*KSIZE+j)*WIDTH +: WIDTH] = mem[(r+i)*IMG_W + (c+j)];
        return v;
    endfunction

    function automatic logic [VW-1:0] exp_addr(input int r, input int c);
        logic [VW-1:0] v;
        for (int i = 0; i < KSIZE; i++)
            for (int j = 0; j < KSIZE; j++)
                v[(i*KSIZE+j)*ADDR_WIDTH +: ADDR_WIDTH] = 16'((r+i)*IMG_W + (c+j));
        return v;
    endfunction

    always @(negedge clk) begin
        int er;
        int ec;
        if (!rst_n) begin
            prev_rd_en = 1'b0;
            seen_fall  = 1'b0;
        end else begin
            if (win_valid) begin
                chk("win_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    er = int'(exp_q[0][31:16]);
                    ec = int'(exp_q[0][15:0]);
                    chk("win_row", 32'(win_row), er);
                    chk("win_col", 32'(win_col), ec);
                    chk("win_last", 32'(win_last), 32'(er == OH-1 && ec == OW-1));
                    chk_wide("win_data", win_data_NP, exp_win(er, ec));
                    chk_wide("rd_addr", rd_addr_NP, exp_addr(er, ec));
                    if (win_ready) begin
                        void'(exp_q.pop_front());
                        hs_row_q.push_back(win_row);
                        hs_col_q.push_back(win_col);
                        hs_p0_q.push_back(win_data_NP[15:0]);
                        hs_p24_q.push_back(win_data_NP[24*WIDTH +: WIDTH]);
                        hs_cyc_q.push_back(cyc);
                        if (win_last) last_cnt++;
                    end
                end
            end
            if (frame_done) begin
                chk("done_on_fall", 32'({prev_rd_en, rd_en}), 2);
                done_cnt++;
                done_cyc = cyc;
            end
            if (prev_rd_en && !rd_en) begin
                chk("fall_has_done", 32'(frame_done), 1);
                seen_fall = 1'b1;
                low_run   = 0;
            end
            if (!rd_en) low_run++;
            if (!prev_rd_en && rd_en && seen_fall) gap_q.push_back(low_run);
            prev_rd_en = rd_en;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_frame();
        for (int r = 0; r < OH; r++)
            for (int c = 0; c < OW; c++)
                exp_q.push_back({16'(r), 16'(c)});
    endtask

    task automatic clear_obs();
        hs_row_q.delete(); hs_col_q.delete(); hs_p0_q.delete();
        hs_p24_q.delete(); hs_cyc_q.delete(); gap_q.delete();
        last_cnt = 0;
    endtask

    task automatic wait_rd_en();
        int n = 0;
        while (rd_en !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        chk("rd_en_rise_timeout", 32'(rd_en), 1);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (win_valid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        chk("valid_timeout", 32'(win_valid), 1);
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 400) begin @(posedge clk); #1; n++; end
        chk("done_timeout", 32'(done_cnt), 32'(target));
    endtask

    task automatic run_windows(input int n, input int max_stall);
        for (int w = 0; w < n; w++) begin
            wait_valid();
            repeat ($urandom_range(0, max_stall)) begin @(posedge clk); #1; end
            win_ready = 1'b1;
            @(posedge clk); #1;
            win_ready = 1'b0;
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int base;
        rst_n = 1'b0;
        data_fill_cnt = 2'd0;
        win_ready = 1'b0;
        for (int a = 0; a < 256; a++) mem[a] = 16'(a);

        // reset held, then idle with no filled half
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_en", 32'(rd_en), 0);
        chk("rst_valid", 32'(win_valid), 0);
        chk("rst_last", 32'(win_last), 0);
        chk("rst_done", 32'(frame_done), 0);
        chk("rst_row", 32'(win_row), 0);
        chk("rst_col", 32'(win_col), 0);
        chk_wide("rst_addr", rd_addr_NP, '0);
        chk_wide("rst_data", win_data_NP, '0);
        rst_n = 1'b1;
        repeat (100) begin
            @(posedge clk); #1;
            chk("idle_rd_en", 32'(rd_en), 0);
            chk("idle_valid", 32'(win_valid), 0);
        end

        // one full frame, consumer always ready
        clear_obs(); push_frame(); base = done_cnt;
        win_ready = 1'b1; data_fill_cnt = 2'd1;
        wait_rd_en(); data_fill_cnt = 2'd0;
        wait_done(base + 1);
        win_ready = 1'b0;
        chk("f1_count", 32'(hs_p0_q.size()), 16);
        chk("f1_lasts", 32'(last_cnt), 1);
        chk("f1_queue_empty", 32'(exp_q.size()), 0);
        if (hs_p0_q.size() == 16) begin
            chk("w0_p0", 32'(hs_p0_q[0]), 0);
            chk("w0_p24", 32'(hs_p24_q[0]), 36);
            chk("w15_p0", 32'(hs_p0_q[15]), 27);
            chk("w15_p24", 32'(hs_p24_q[15]), 63);
            chk("w15_row", 32'(hs_row_q[15]), 3);
            chk("w15_col", 32'(hs_col_q[15]), 3);
            chk("done_after_last_hs", 32'(done_cyc - hs_cyc_q[15]), 1);
            for (int k = 0; k < 15; k++)
                chk("window_period", 32'(hs_cyc_q[k+1] - hs_cyc_q[k]), 32'(RD_LAT + 3));
        end

        // 10-cycle stall on window 5 (1,1)
        clear_obs(); push_frame(); base = done_cnt;
        data_fill_cnt = 2'd1;
        wait_rd_en(); data_fill_cnt = 2'd0;
        run_windows(5, 0);
        wait_valid();
        repeat (10) begin
            @(posedge clk); #1;
            chk("stall_valid", 32'(win_valid), 1);
            chk("stall_p0", 32'(win_data_NP[15:0]), 9);
            chk("stall_addr0", 32'(rd_addr_NP[15:0]), 9);
            chk("stall_addr24", 32'(rd_addr_NP[24*ADDR_WIDTH +: ADDR_WIDTH]), 45);
            chk("stall_row", 32'(win_row), 1);
            chk("stall_col", 32'(win_col), 1);
        end
        win_ready = 1'b1;
        @(posedge clk); #1;
        win_ready = 1'b0;
        run_windows(10, 2);
        wait_done(base + 1);
        chk("f2_count", 32'(hs_row_q.size()), 16);
        if (hs_row_q.size() == 16) begin
            chk("after_stall_row", 32'(hs_row_q[6]), 1);
            chk("after_stall_col", 32'(hs_col_q[6]), 2);
        end

        // two back-to-back frames
        clear_obs(); push_frame(); push_frame(); base = done_cnt;
        win_ready = 1'b1; data_fill_cnt = 2'd2;
        wait_done(base + 1);
        @(posedge clk); #1;
        data_fill_cnt = 2'd1;
        wait_rd_en(); data_fill_cnt = 2'd0;
        wait_done(base + 2);
        win_ready = 1'b0;
        chk("b2b_count", 32'(hs_row_q.size()), 32);
        chk("b2b_lasts", 32'(last_cnt), 2);
        chk("b2b_gap_seen", 32'(gap_q.size() > 0), 1);
        if (gap_q.size() > 0) chk("b2b_gap_ge2", 32'(gap_q[gap_q.size()-1] >= 2), 1);

        // reset in the middle of window 7
        clear_obs(); push_frame();
        data_fill_cnt = 2'd1;
        wait_rd_en(); data_fill_cnt = 2'd0;
        run_windows(7, 1);
        wait_valid();
        chk("w7_row", 32'(win_row), 1);
        chk("w7_col", 32'(win_col), 3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rd_en", 32'(rd_en), 0);
        chk("mid_rst_valid", 32'(win_valid), 0);
        chk("mid_rst_row", 32'(win_row), 0);
        chk("mid_rst_col", 32'(win_col), 0);
        chk_wide("mid_rst_addr", rd_addr_NP, '0);
        chk_wide("mid_rst_data", win_data_NP, '0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_obs(); push_frame(); base = done_cnt;
        win_ready = 1'b1; data_fill_cnt = 2'd1;
        wait_rd_en(); data_fill_cnt = 2'd0;
        wait_done(base + 1);
        win_ready = 1'b0;
        chk("restart_count", 32'(hs_row_q.size()), 16);
        if (hs_row_q.size() > 0) begin
            chk("restart_row", 32'(hs_row_q[0]), 0);
            chk("restart_col", 32'(hs_col_q[0]), 0);
        end

        // fill drops to 0 mid-frame
        clear_obs(); push_frame(); base = done_cnt;
        data_fill_cnt = 2'd1;
        wait_rd_en();
        run_windows(8, 2);
        data_fill_cnt = 2'd0;
        run_windows(8, 2);
        wait_done(base + 1);
        chk("filldrop_count", 32'(hs_row_q.size()), 16);
        chk("filldrop_lasts", 32'(last_cnt), 1);

        // random map contents and random stalls
        for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
        clear_obs(); push_frame(); base = done_cnt;
        data_fill_cnt = 2'($urandom_range(1, 3));
        wait_rd_en(); data_fill_cnt = 2'd0;
        run_windows(16, 3);
        wait_done(base + 1);
        chk("rand_count", 32'(hs_row_q.size()), 16);
        chk("rand_queue_empty", 32'(exp_q.size()), 0);

        repeat (5) @(posedge clk);
        #1;
        chk("end_rd_en", 32'(rd_en), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
